// File: rtl/scan_chain_controller.sv
// Scan chain controller: loads a word into a serial DFF chain LSB-first
// while capturing the chain's previous contents from its tail.
module scan_chain_controller #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] wdata,
  input  logic             hold,
  output logic             scan_en,
  output logic             scan_out,
  input  logic             scan_in,
  output logic             update,
  output logic [WIDTH-1:0] rdata,
  output logic             rdata_valid,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    UPDATE,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] tx_reg;
  logic [WIDTH-1:0] rx_reg;
  logic [CW-1:0]    cnt;
  logic             shifting;

  assign shifting = (state == SHIFT);

  // hold must gate the chain in the same cycle it freezes the counter
  assign scan_en  = shifting & ~hold;
  assign scan_out = shifting & tx_reg[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      tx_reg      <= '0;
      rx_reg      <= '0;
      rdata       <= '0;
      cnt         <= '0;
      start_ready <= 1'b1;
      busy        <= 1'b0;
      update      <= 1'b0;
      rdata_valid <= 1'b0;
    end else begin
      update      <= 1'b0;
      rdata_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_valid) begin
            tx_reg      <= wdata;
            rx_reg      <= '0;
            cnt         <= '0;
            state       <= SHIFT;
            start_ready <= 1'b0;
            busy        <= 1'b1;
          end
        end
        SHIFT: begin
          if (!hold) begin
            tx_reg <= {1'b0, tx_reg[WIDTH-1:1]};
            rx_reg <= {scan_in, rx_reg[WIDTH-1:1]};
            if (cnt == LAST) begin
              cnt    <= '0;
              state  <= UPDATE;
              update <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        UPDATE: begin
          rdata       <= rx_reg;
          state       <= DONE;
          rdata_valid <= 1'b1;
        end
        DONE: begin
          state       <= IDLE;
          start_ready <= 1'b1;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule
